// File: rtl/spmv_scratch_pad_if.sv
// Request/response bundle between an spmv_pe (master) and its scratchpad (slave).
interface spmv_scratch_pad_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 64
);
    logic                  req_scratch_ld;
    logic                  req_scratch_st;
    logic [ADDR_WIDTH-1:0] req_scratch_addr;
    logic [DATA_WIDTH-1:0] req_scratch_d;
    logic                  req_scratch_stall;
    logic                  rsp_scratch_push;
    logic [DATA_WIDTH-1:0] rsp_scratch_q;
    logic                  rsp_scratch_stall;

    modport master (
        output req_scratch_ld, req_scratch_st, req_scratch_addr, req_scratch_d,
        output rsp_scratch_stall,
        input  req_scratch_stall, rsp_scratch_push, rsp_scratch_q
    );

    modport slave (
        input  req_scratch_ld, req_scratch_st, req_scratch_addr, req_scratch_d,
        input  rsp_scratch_stall,
        output req_scratch_stall, rsp_scratch_push, rsp_scratch_q
    );
endinterface

// File: rtl/spmv_scratch_pad.sv
// PE scratchpad: single-ported RAM with a fixed-latency read pipeline feeding an
// in-order response FIFO. The initiator is throttled by a registered credit stall
// that leaves two entries of slack; a read arriving with every credit consumed is
// dropped and flagged in err_overflow.
// Parameter constraints: DEPTH <= 2**ADDR_WIDTH, READ_LATENCY >= 1,
// FIFO_DEPTH >= READ_LATENCY + 3.
module spmv_scratch_pad #(
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 8192,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    spmv_scratch_pad_if.slave bus,
    output logic              err_overflow
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int OW     = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [OW-1:0]       STALL_LEVEL = OW'(FIFO_DEPTH - 2);
    localparam logic [OW-1:0]       FULL_LEVEL  = OW'(FIFO_DEPTH);
    localparam logic [PW-1:0]       LAST_SLOT   = PW'(FIFO_DEPTH - 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [OW-1:0]           fifo_count;
    logic [OW-1:0]           outstanding;
    logic [OW-1:0]           outstanding_next;
    state_t                  state;

    logic              in_range;
    logic [MEM_AW-1:0] mem_idx;
    logic              ld_overflow;
    logic              ld_accept;
    logic              fifo_wr;
    logic              fifo_pop;

    assign in_range    = {1'b0, bus.req_scratch_addr} < DEPTH_LIMIT;
    assign mem_idx     = bus.req_scratch_addr[MEM_AW-1:0];
    assign ld_overflow = bus.req_scratch_ld && (outstanding == FULL_LEVEL);
    assign ld_accept   = bus.req_scratch_ld && !ld_overflow;
    assign fifo_wr     = pipe_valid[READ_LATENCY-1];
    assign fifo_pop    = (fifo_count != '0) && !bus.rsp_scratch_stall;

    // Credits in use after this edge: in-flight reads plus queued responses.
    always_comb begin
        outstanding_next = outstanding + OW'(ld_accept) - OW'(fifo_pop);
    end

    // RAM port (read-first on a same-address collision) and read data pipeline.
    always_ff @(posedge clk) begin
        if (bus.req_scratch_st && in_range) begin
            mem[mem_idx] <= bus.req_scratch_d;
        end
        if (bus.req_scratch_ld) begin
            pipe_data[0] <= in_range ? mem[mem_idx] : '0;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    // Valid bits travelling alongside the read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= ld_accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Response FIFO storage, written as read data leaves the pipeline.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= pipe_data[READ_LATENCY-1];
        end
    end

    // FIFO pointers, occupancy, credit counter, request stall and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            fifo_count            <= '0;
            outstanding           <= '0;
            bus.req_scratch_stall <= 1'b0;
            err_overflow          <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            end
            fifo_count            <= fifo_count + OW'(fifo_wr) - OW'(fifo_pop);
            outstanding           <= outstanding_next;
            bus.req_scratch_stall <= (outstanding_next >= STALL_LEVEL);
            if (ld_overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // Response output FSM: each pop loads one registered push with the head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            bus.rsp_scratch_push <= 1'b0;
            bus.rsp_scratch_q    <= '0;
        end else begin
            bus.rsp_scratch_push <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        state                <= SEND;
                        bus.rsp_scratch_push <= 1'b1;
                        bus.rsp_scratch_q    <= fifo_mem[rd_ptr];
                    end
                end
                SEND: begin
                    if (fifo_pop) begin
                        bus.rsp_scratch_push <= 1'b1;
                        bus.rsp_scratch_q    <= fifo_mem[rd_ptr];
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spmv_scratch_pad.sv
// Self-checking bench for spmv_scratch_pad, built with DEPTH = 4096 so that the
// upper half of the 13-bit address space is out of range.
module tb_spmv_scratch_pad;
    localparam int AW    = 13;
    localparam int DW    = 64;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_overflow;

    always #5 clk = ~clk;

    spmv_scratch_pad_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    spmv_scratch_pad #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .READ_LATENCY(2), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .err_overflow(err_overflow)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] got [$];

    // Collect every pushed response, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.rsp_scratch_push === 1'b1) got.push_back(bus.rsp_scratch_q);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.req_scratch_ld = 1'b0;
        bus.req_scratch_st = 1'b0;
    endtask

    task automatic store(input int a, input logic [DW-1:0] d);
        bus.req_scratch_st   = 1'b1;
        bus.req_scratch_addr = AW'(a);
        bus.req_scratch_d    = d;
        tick();
        bus.req_scratch_st = 1'b0;
        if (a < DEPTH) model_mem[a] = d;
    endtask

    task automatic load(input int a);
        bus.req_scratch_ld   = 1'b1;
        bus.req_scratch_addr = AW'(a);
        tick();
        bus.req_scratch_ld = 1'b0;
    endtask

    task automatic wait_pushes(input int n, input int budget);
        int c;
        c = 0;
        while (got.size() < n && c < budget) begin
            tick();
            c++;
        end
        repeat (6) tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_bus();
        bus.rsp_scratch_stall = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        got.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.rsp_scratch_push !== 1'b0) begin errors++; $display("[TB] FAIL reset_push: got %b expected 0", bus.rsp_scratch_push); end
        checks++; if (bus.rsp_scratch_q !== '0) begin errors++; $display("[TB] FAIL reset_q: got %h expected 0", bus.rsp_scratch_q); end
        checks++; if (bus.req_scratch_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.req_scratch_stall); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err_overflow); end
    endtask

    task automatic test_round_trip();
        logic exp_push;
        store(5, 64'h0123456789ABCDEF);
        load(5);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            exp_push = (k == 3);
            checks++;
            if (bus.rsp_scratch_push !== exp_push) begin
                errors++;
                $display("[TB] FAIL round_trip_push_cycle%0d: got %b expected %b", k + 1, bus.rsp_scratch_push, exp_push);
            end
            if (k == 3) begin
                checks++;
                if (bus.rsp_scratch_q !== model_mem[5]) begin
                    errors++;
                    $display("[TB] FAIL round_trip_q: got %h expected %h", bus.rsp_scratch_q, model_mem[5]);
                end
            end
        end
        got.delete();
    endtask

    task automatic test_read_first();
        store(7, 64'd1);
        bus.req_scratch_ld   = 1'b1;
        bus.req_scratch_st   = 1'b1;
        bus.req_scratch_addr = AW'(7);
        bus.req_scratch_d    = 64'd2;
        tick();
        idle_bus();
        load(7);
        wait_pushes(2, 40);
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("[TB] FAIL read_first_count: got %0d expected 2", got.size());
        end else begin
            checks++; if (got[0] !== 64'd1) begin errors++; $display("[TB] FAIL read_first_old: got %h expected 1", got[0]); end
            checks++; if (got[1] !== 64'd2) begin errors++; $display("[TB] FAIL read_first_new: got %h expected 2", got[1]); end
        end
        model_mem[7] = 64'd2;
        got.delete();
    endtask

    task automatic test_stall_order();
        int n;
        int guard;
        for (int i = 0; i < 16; i++) store(i, DW'(i));
        got.delete();
        bus.rsp_scratch_stall = 1'b1;
        n = 0;
        guard = 0;
        while (n < 16 && bus.req_scratch_stall !== 1'b1 && guard < 100) begin
            load(n);
            n++;
            guard++;
        end
        checks++;
        if (n != 6) begin errors++; $display("[TB] FAIL stall_threshold: got %0d loads before stall expected 6", n); end
        repeat (5) tick();
        checks++; if (got.size() != 0) begin errors++; $display("[TB] FAIL stall_no_push: got %0d pushes expected 0", got.size()); end
        checks++; if (bus.req_scratch_stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_held: got %b expected 1", bus.req_scratch_stall); end
        bus.rsp_scratch_stall = 1'b0;
        guard = 0;
        while (n < 16 && guard < 200) begin
            if (bus.req_scratch_stall !== 1'b1) begin
                bus.req_scratch_ld   = 1'b1;
                bus.req_scratch_addr = AW'(n);
                n++;
            end else begin
                bus.req_scratch_ld = 1'b0;
            end
            tick();
            guard++;
        end
        idle_bus();
        wait_pushes(16, 100);
        checks++;
        if (got.size() != 16) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d expected 16", got.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got[i] !== model_mem[i]) begin
                    errors++;
                    $display("[TB] FAIL stall_order[%0d]: got %h expected %h", i, got[i], model_mem[i]);
                end
            end
        end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL stall_err: got %b expected 0", err_overflow); end
        got.delete();
    endtask

    task automatic test_overflow();
        bus.rsp_scratch_stall = 1'b1;
        got.delete();
        for (int i = 0; i < 9; i++) begin
            load(i);
            if (i == 7) begin
                checks++;
                if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL overflow_early: got %b expected 0", err_overflow); end
            end
        end
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_set: got %b expected 1", err_overflow); end
        bus.rsp_scratch_stall = 1'b0;
        wait_pushes(8, 100);
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("[TB] FAIL overflow_count: got %0d expected 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== model_mem[i]) begin
                    errors++;
                    $display("[TB] FAIL overflow_data[%0d]: got %h expected %h", i, got[i], model_mem[i]);
                end
            end
        end
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_sticky: got %b expected 1", err_overflow); end
        apply_reset();
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL overflow_clear: got %b expected 0", err_overflow); end
    endtask

    task automatic test_out_of_range();
        store(0, {$urandom, $urandom} | 64'h1);
        store(DEPTH, 64'd9);
        load(DEPTH);
        load(0);
        wait_pushes(2, 40);
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("[TB] FAIL oor_count: got %0d expected 2", got.size());
        end else begin
            checks++; if (got[0] !== '0) begin errors++; $display("[TB] FAIL oor_q: got %h expected 0", got[0]); end
            checks++; if (got[1] !== model_mem[0]) begin errors++; $display("[TB] FAIL oor_ram0: got %h expected %h", got[1], model_mem[0]); end
        end
        got.delete();
    endtask

    task automatic test_reset_midflight();
        checks++;
        if (bus.rsp_scratch_q !== model_mem[0]) begin errors++; $display("[TB] FAIL midflight_q_hold: got %h expected %h", bus.rsp_scratch_q, model_mem[0]); end
        load(1);
        load(2);
        bus.req_scratch_ld   = 1'b1;
        bus.req_scratch_addr = AW'(3);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rsp_scratch_push !== 1'b0) begin errors++; $display("[TB] FAIL midflight_push: got %b expected 0", bus.rsp_scratch_push); end
        checks++; if (bus.rsp_scratch_q !== '0) begin errors++; $display("[TB] FAIL midflight_q: got %h expected 0", bus.rsp_scratch_q); end
        checks++; if (bus.req_scratch_stall !== 1'b0) begin errors++; $display("[TB] FAIL midflight_stall: got %b expected 0", bus.req_scratch_stall); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL midflight_err: got %b expected 0", err_overflow); end
        idle_bus();
        tick();
        tick();
        rst_n = 1'b1;
        got.delete();
        repeat (12) tick();
        checks++; if (got.size() != 0) begin errors++; $display("[TB] FAIL midflight_no_push: got %0d pushes expected 0", got.size()); end
        checks++; if (bus.req_scratch_stall !== 1'b0) begin errors++; $display("[TB] FAIL midflight_stall_after: got %b expected 0", bus.req_scratch_stall); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q [$];
        int a;
        logic do_ld;
        logic do_st;
        logic [DW-1:0] d;
        apply_reset();
        for (int i = 0; i < 32; i++) store(i, {$urandom, $urandom});
        got.delete();
        for (int c = 0; c < 400; c++) begin
            bus.rsp_scratch_stall = ($urandom_range(0, 9) < 3);
            a = ($urandom_range(0, 15) == 0) ? DEPTH + $urandom_range(0, 100) : $urandom_range(0, 31);
            do_ld = (bus.req_scratch_stall !== 1'b1) && ($urandom_range(0, 1) == 1);
            do_st = ($urandom_range(0, 3) == 0);
            d = {$urandom, $urandom};
            bus.req_scratch_ld   = do_ld;
            bus.req_scratch_st   = do_st;
            bus.req_scratch_addr = AW'(a);
            bus.req_scratch_d    = d;
            if (do_ld) exp_q.push_back((a < DEPTH) ? model_mem[a] : '0);
            if (do_st && a < DEPTH) model_mem[a] = d;
            tick();
        end
        idle_bus();
        bus.rsp_scratch_stall = 1'b0;
        wait_pushes(exp_q.size(), 200);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL random_count: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL random_data[%0d]: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL random_err: got %b expected 0", err_overflow); end
    endtask

    initial begin
        bus.req_scratch_ld    = 1'b0;
        bus.req_scratch_st    = 1'b0;
        bus.req_scratch_addr  = '0;
        bus.req_scratch_d     = '0;
        bus.rsp_scratch_stall = 1'b0;
        test_reset();
        test_round_trip();
        test_read_first();
        test_stall_order();
        test_overflow();
        test_out_of_range();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spmv_scratch_pad.md
Name: spmv_scratch_pad

Overview:
- Synthesizable responder for the PE scratchpad request/response interface; it is the target side of req_scratch_* and the source of rsp_scratch_*.
- Holds one PE's 64-bit working set: delta codes, prefix codes and common doubles.
- Single-ported RAM with fixed read latency, in-order response FIFO and credit-style request stall.
- Replaces the behavioural scratchpad model in system builds; one instance per spmv_pe.

Parameters:
- ADDR_WIDTH, 13, width of req_scratch_addr.
- DATA_WIDTH, 64, word width.
- DEPTH, 8192, number of RAM words; must be <= 2**ADDR_WIDTH.
- READ_LATENCY, 2, RAM read pipeline stages; must be >= 1.
- FIFO_DEPTH, 8, response FIFO entries; must be >= READ_LATENCY + 3.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_scratch_ld  in  1  read request, valid for one cycle.
- req_scratch_st  in  1  write request, valid for one cycle.
- req_scratch_addr  in  ADDR_WIDTH  word address.
- req_scratch_d  in  DATA_WIDTH  write data.
- req_scratch_stall  out  1  registered; initiator must stop issuing.
- rsp_scratch_push  out  1  registered; rsp_scratch_q valid this cycle.
- rsp_scratch_q  out  DATA_WIDTH  registered read data.
- rsp_scratch_stall  in  1  downstream cannot accept a push this cycle.
- err_overflow  out  1  sticky; a read was accepted with no FIFO space.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs go to 0, FIFO is empty, pipeline valid bits clear, credit counter is 0. RAM contents are not reset. Reset mid-operation discards in-flight reads and queued responses; no push occurs after release until a new ld arrives.
- Writes: st sampled at an edge writes RAM[addr] at that edge. There is no response for a write. Writes are never stalled internally.
- Reads: ld sampled at edge E0 enters the pipeline. Data enters the FIFO at edge E(READ_LATENCY). Earliest rsp_scratch_push is high in the cycle after edge E(READ_LATENCY+1), i.e. minimum latency is READ_LATENCY+1 cycles (3 at default).
- Ordering: responses are in request order. One push per cycle maximum.
- ld and st in the same cycle, same address: read-first, so ld returns the old data. A ld one cycle after a st to the same address returns the new data.
- Out of range (addr >= DEPTH): ld still produces a response with q = 0; st is dropped.
- Credits: outstanding = in-flight pipeline reads + FIFO occupancy.
  - req_scratch_stall <= (outstanding_next >= FIFO_DEPTH - 2).
  - Two cycles of slack cover a registered stall and an initiator that reacts one cycle late.
  - A ld accepted while outstanding == FIFO_DEPTH sets err_overflow (sticky until reset), and that response is dropped.
- Response output FSM, two states:
  - IDLE: push = 0. Moves to SEND when the FIFO is non-empty and rsp_scratch_stall is low.
  - SEND: push = 1 for one cycle with the head data and pops the head. Stays in SEND if another entry exists and rsp_scratch_stall is low; otherwise returns to IDLE.
  - rsp_scratch_stall is sampled at the edge that would load the push; when it is high, push is 0 next cycle and the head is retained.
- Simultaneous FIFO write and pop in one cycle leaves occupancy unchanged. The FIFO pointers wrap modulo FIFO_DEPTH.
- q holds its last pushed value while push = 0. Its value is only meaningful when push = 1.

Test Plan:
- Basic round trip: reset, then st addr 5 = 64'h0123456789ABCDEF; one cycle later ld addr 5 -> push for exactly one cycle, 3 cycles after ld, q = 64'h0123456789ABCDEF.
- Read-first collision: RAM[7] = 1, then same cycle st addr 7 = 2 and ld addr 7 -> q = 1; next ld addr 7 -> q = 2.
- Stall and ordering: load addr i with i for i = 0..15, hold rsp_scratch_stall high, issue ld 0..15 honoring req_scratch_stall -> stall rises after 6 outstanding, no push while rsp_scratch_stall is high. Release -> 16 pushes with q = 0..15 in order; err_overflow stays 0.
- Overflow: hold rsp_scratch_stall high, ignore req_scratch_stall, issue 9 consecutive lds -> err_overflow = 1 after the 9th; on release exactly 8 pushes.
- Out of range: DEPTH = 4096, st addr 4096 = 9 then ld addr 4096 -> q = 0; RAM[0] unchanged.
- Reset mid-flight: issue 3 lds, assert rst_n low 1 cycle after the 2nd -> all outputs 0 immediately; after release no push and stall = 0.
